// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the RV32I core: XLEN, sequencer state encoding and base opcodes.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEM       = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_TRAP      = 3'd6;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction- and data-memory request/acknowledge handshakes of the core sequencer.
interface core_sequencer_if;
  import core_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );

endinterface

// File: rtl/core_sequencer_next_pc.sv
// next_pc_unit: combinational next-PC select (PC+4, PC+imm, or JALR target) with misalignment flag.
module next_pc_unit
  import core_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            taken_br,
  input  logic            is_jal,
  input  logic            is_jalr,
  output logic [XLEN-1:0] pc_next,
  output logic            misaligned
);

  logic redirect;
  logic unused_alu_lsb;

  // JALR clears bit 0 of the target, so the ALU's LSB never reaches the PC.
  assign unused_alu_lsb = alu_result[0];

  always_comb begin
    pc_next  = pc + 32'd4;
    redirect = 1'b0;
    if (is_jal || taken_br) begin
      pc_next  = pc + imm;
      redirect = 1'b1;
    end else if (is_jalr) begin
      pc_next  = {alu_result[XLEN-1:1], 1'b0};
      redirect = 1'b1;
    end
  end

  assign misaligned = redirect && (pc_next[1:0] != 2'b00);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM owning the PC; CORE_SEQ_TRAP_EN enables the TRAP state
// for illegal instructions and misaligned jump/branch targets.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  core_sequencer_if.master    mem,
  output logic [XLEN-1:0]     instr,
  input  logic                is_load,
  input  logic                is_store,
  input  logic                is_jal,
  input  logic                is_jalr,
  input  logic                illegal,
  input  logic                taken_br,
  input  logic [XLEN-1:0]     imm,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                rd_valid,
  input  logic [4:0]          rd,
  output logic                rf_we,
  output logic [XLEN-1:0]     pc,
  output logic                retire,
  output logic [XLEN-1:0]     retire_cnt,
  output logic [2:0]          state,
  output logic                trap
);

  logic [2:0]      state_d;
  logic [XLEN-1:0] npu_next;
  logic [XLEN-1:0] pc_next_d;
  logic [XLEN-1:0] pc_next_q;
  logic            misaligned;
  logic            mem_op;

  next_pc_unit u_next_pc (
    .pc         (pc),
    .imm        (imm),
    .alu_result (alu_result),
    .taken_br   (taken_br),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .pc_next    (npu_next),
    .misaligned (misaligned)
  );

  // An illegal instruction that does not trap degrades to a NOP: fall through, no memory access.
  assign pc_next_d = illegal ? (pc + 32'd4) : npu_next;
  assign mem_op    = (is_load || is_store) && !illegal;

`ifdef CORE_SEQ_TRAP_EN
  logic take_trap;
  assign take_trap = illegal || misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH:     if (mem.imem_ack) state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE: begin
`ifdef CORE_SEQ_TRAP_EN
        if (take_trap)   state_d = S_TRAP;
        else if (mem_op) state_d = S_MEM;
        else             state_d = S_WRITEBACK;
`else
        if (mem_op) state_d = S_MEM;
        else        state_d = S_WRITEBACK;
`endif
      end
      S_MEM:       if (mem.dmem_ack) state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = run ? S_FETCH : S_IDLE;
`ifdef CORE_SEQ_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem.imem_req  = (state == S_FETCH);
    mem.imem_addr = pc;
    mem.dmem_req  = (state == S_MEM);
    mem.dmem_we   = (state == S_MEM) && is_store;
    retire        = (state == S_WRITEBACK);
    rf_we         = (state == S_WRITEBACK) && rd_valid && (rd != 5'd0) && !is_store && !illegal;
`ifdef CORE_SEQ_TRAP_EN
    trap          = (state == S_TRAP);
`else
    trap          = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      instr      <= '0;
      retire_cnt <= '0;
    end else begin
      if (state == S_FETCH && mem.imem_ack) instr <= mem.imem_rdata;
      if (state == S_WRITEBACK) begin
        pc         <= pc_next_q;
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

  // The target is only consumed in WRITEBACK, after EXECUTE has always written it.
  always_ff @(posedge clk) begin
    if (state == S_EXECUTE) pc_next_q <= pc_next_d;
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: randomized memory latency and instruction mixes vs. a per-instruction model.
module tb_core_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] instr;
  logic        is_load, is_store, is_jal, is_jalr, illegal, taken_br;
  logic [31:0] imm, alu_result;
  logic        rd_valid;
  logic [4:0]  rd;
  logic        rf_we, retire, trap;
  logic [31:0] pc, retire_cnt;
  logic [2:0]  state;

  core_sequencer_if mif ();

  core_sequencer #(.RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .mem        (mif.master),
    .instr      (instr),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .illegal    (illegal),
    .taken_br   (taken_br),
    .imm        (imm),
    .alu_result (alu_result),
    .rd_valid   (rd_valid),
    .rd         (rd),
    .rf_we      (rf_we),
    .pc         (pc),
    .retire     (retire),
    .retire_cnt (retire_cnt),
    .state      (state),
    .trap       (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_cnt  = 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    is_load = 0; is_store = 0; is_jal = 0; is_jalr = 0; illegal = 0; taken_br = 0;
    imm = 0; alu_result = 0; rd_valid = 0; rd = 0;
    mif.imem_ack = 0; mif.imem_rdata = 0; mif.dmem_ack = 0;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 branch, 4 jal, 5 jalr. Called with the DUT in FETCH.
  task automatic do_instr(input int kind, input logic [31:0] imm_v, input logic [31:0] alu_v,
                          input logic tk, input logic rdv, input logic [4:0] rdi, input logic ill,
                          input int iw, input int dw, input logic noise);
    logic [31:0] word, exp_next;
    bit          memop, exp_we, done;
    int          exp_cycles, c, fw, mw;
    word = $urandom;
    is_load = (kind == 1); is_store = (kind == 2); is_jal = (kind == 4); is_jalr = (kind == 5);
    taken_br = (kind == 3) && tk; imm = imm_v; alu_result = alu_v;
    rd_valid = rdv; rd = rdi; illegal = ill;
    memop = (kind == 1 || kind == 2) && !ill;
    if (ill)                                exp_next = m_pc + 32'd4;
    else if (kind == 4 || (kind == 3 && tk)) exp_next = m_pc + imm_v;
    else if (kind == 5)                     exp_next = alu_v & 32'hFFFF_FFFE;
    else                                    exp_next = m_pc + 32'd4;
    exp_we = rdv && (rdi != 0) && (kind != 2) && !ill;
    exp_cycles = 4 + iw + (memop ? 1 + dw : 0);

    checks++;
    if (mif.imem_req !== 1'b1 || mif.imem_addr !== m_pc) begin
      errors++;
      $display("FAIL fetch_start: imem_req=%b addr=%h, required 1 and %h", mif.imem_req, mif.imem_addr, m_pc);
    end
    fw = 0; mw = 0; c = 1; done = 0;
    while (!done && c <= 40) begin
      mif.imem_ack = 0; mif.dmem_ack = 0;
      if (mif.imem_req) begin
        mif.imem_rdata = word;
        if (fw == iw) mif.imem_ack = 1;
        fw++;
      end else if (noise) begin
        mif.imem_ack = 1'($urandom_range(0, 1));
        mif.imem_rdata = $urandom;
      end
      if (mif.dmem_req) begin
        checks++;
        if (mif.dmem_we !== (kind == 2)) begin
          errors++;
          $display("FAIL dmem_we: got %b required %b", mif.dmem_we, (kind == 2));
        end
        if (mw == dw) mif.dmem_ack = 1;
        mw++;
      end else if (noise) begin
        mif.dmem_ack = 1'($urandom_range(0, 1));
      end
      if (retire) begin
        done = 1;
        checks += 4;
        if (rf_we !== exp_we) begin errors++; $display("FAIL rf_we: got %b required %b", rf_we, exp_we); end
        if (pc !== m_pc) begin errors++; $display("FAIL pc_stable: got %h required %h", pc, m_pc); end
        if (instr !== word) begin errors++; $display("FAIL instr: got %h required %h", instr, word); end
        if (c !== exp_cycles) begin errors++; $display("FAIL cycles: retire at %0d required %0d", c, exp_cycles); end
      end else begin
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL rf_we_early: got %b required 0 at cycle %0d", rf_we, c); end
      end
      tick();
      c++;
    end
    mif.imem_ack = 0; mif.dmem_ack = 0;
    checks++;
    if (!done) begin errors++; $display("FAIL retire_timeout: no retire in %0d cycles, required %0d", c - 1, exp_cycles); end
    m_pc = exp_next;
    m_cnt = m_cnt + 32'd1;
    checks += 3;
    if (pc !== m_pc) begin errors++; $display("FAIL next_pc: got %h required %h", pc, m_pc); end
    if (retire_cnt !== m_cnt) begin errors++; $display("FAIL retire_cnt: got %h required %h", retire_cnt, m_cnt); end
    if (retire !== 1'b0) begin errors++; $display("FAIL retire_pulse: got %b required 0", retire); end
  endtask

  task automatic goto_pc(input logic [31:0] target);
    do_instr(4, target - m_pc, 32'h0, 0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 0; run = 0;
    clear_inputs();
    tick(); tick();
    checks += 8;
    if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d required 0", state); end
    if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h required 0", pc); end
    if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h required 0", instr); end
    if (retire_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %h required 0", retire_cnt); end
    if (mif.imem_req !== 1'b0 || mif.dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b%b required 00", mif.imem_req, mif.dmem_req); end
    if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we: got %b required 0", rf_we); end
    if (retire !== 1'b0) begin errors++; $display("FAIL rst_retire: got %b required 0", retire); end
    if (trap !== 1'b0) begin errors++; $display("FAIL rst_trap: got %b required 0", trap); end
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (state !== 3'd0 || mif.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: state=%0d imem_req=%b required 0 and 0", state, mif.imem_req);
      end
    end
    m_pc = 32'h0; m_cnt = 32'h0;
  endtask

  task automatic test_addi();
    run = 1;
    tick();
    do_instr(0, 32'h5, 32'h5, 0, 1, 5'd1, 0, 0, 0, 0);
    checks++;
    if (pc !== 32'h4) begin errors++; $display("FAIL addi_pc: got %h required 4", pc); end
  endtask

  task automatic test_load();
    do_instr(1, 32'h10, 32'h1000, 0, 1, 5'd3, 0, 2, 3, 0);
    do_instr(2, 32'h14, 32'h2000, 0, 0, 5'd0, 0, 1, 0, 0);
  endtask

  task automatic test_branch();
    goto_pc(32'h20);
    do_instr(3, 32'hFFFF_FFF8, 32'h0, 1, 0, 5'd0, 0, 0, 0, 0);
    checks++;
    if (mif.imem_addr !== 32'h18) begin errors++; $display("FAIL br_taken: got %h required 18", mif.imem_addr); end
    goto_pc(32'h20);
    do_instr(3, 32'hFFFF_FFF8, 32'h0, 0, 0, 5'd0, 0, 0, 0, 0);
    checks++;
    if (mif.imem_addr !== 32'h24) begin errors++; $display("FAIL br_not_taken: got %h required 24", mif.imem_addr); end
  endtask

  task automatic test_jalr();
    do_instr(5, 32'h0, 32'h101, 0, 1, 5'd1, 0, 0, 0, 0);
    checks++;
    if (pc !== 32'h100) begin errors++; $display("FAIL jalr_pc: got %h required 100", pc); end
    do_instr(5, 32'h0, 32'h101, 0, 1, 5'd0, 0, 1, 0, 0);
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    do_instr(0, 32'h0, 32'h0, 0, 1, 5'd7, 0, 0, 0, 0);
    checks++;
    if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h required 0", pc); end
  endtask

  task automatic test_run_stop();
    run = 0;
    do_instr(0, 32'h0, 32'h0, 0, 1, 5'd2, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state !== 3'd0 || mif.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL run_stop: state=%0d imem_req=%b required 0 and 0", state, mif.imem_req);
      end
      tick();
    end
    run = 1;
    tick();
  endtask

  task automatic test_random();
    int          kind;
    logic [31:0] iv, av;
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 5);
      iv = $urandom & 32'hFFFF_FFFC;
      av = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      do_instr(kind, iv, av, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), 0, $urandom_range(0, 3), $urandom_range(0, 3), 1);
    end
  endtask

  task automatic test_reset_in_mem();
    bit seen;
    seen = 0;
    is_load = 1; is_store = 0; is_jal = 0; is_jalr = 0; taken_br = 0; illegal = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      mif.imem_ack = 0;
      if (mif.dmem_req) seen = 1;
      else begin
        if (mif.imem_req) begin mif.imem_ack = 1; mif.imem_rdata = 32'h0000_2003; end
        tick();
      end
    end
    mif.imem_ack = 0;
    checks++;
    if (!seen) begin errors++; $display("FAIL mem_reach: dmem_req never seen, required within 20 cycles"); end
    reset = 0;
    #1;
    checks += 5;
    if (mif.dmem_req !== 1'b0) begin errors++; $display("FAIL rst_dmem_req: got %b required 0", mif.dmem_req); end
    if (state !== 3'd0) begin errors++; $display("FAIL rst_mem_state: got %0d required 0", state); end
    if (pc !== 32'h0) begin errors++; $display("FAIL rst_mem_pc: got %h required 0", pc); end
    if (retire_cnt !== 32'h0) begin errors++; $display("FAIL rst_mem_cnt: got %h required 0", retire_cnt); end
    if (instr !== 32'h0) begin errors++; $display("FAIL rst_mem_instr: got %h required 0", instr); end
    tick();
    reset = 1;
    m_pc = 32'h0; m_cnt = 32'h0;
    clear_inputs();
    tick();
  endtask

  task automatic test_illegal();
    goto_pc(32'h8);
`ifdef CORE_SEQ_TRAP_EN
    begin
      bit hit;
      hit = 0;
      illegal = 1; is_load = 0; is_store = 0; is_jal = 0; is_jalr = 0; taken_br = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
        mif.imem_ack = mif.imem_req;
        if (trap) hit = 1;
        else tick();
      end
      mif.imem_ack = 0;
      checks++;
      if (!hit) begin errors++; $display("FAIL trap_timeout: trap=%b required 1", trap); end
      for (int i = 0; i < 4; i++) begin
        tick();
        checks++;
        if (trap !== 1'b1 || pc !== 32'h8 || mif.imem_req !== 1'b0 || retire !== 1'b0) begin
          errors++;
          $display("FAIL trap_hold: trap=%b pc=%h imem_req=%b retire=%b required 1 8 0 0", trap, pc, mif.imem_req, retire);
        end
      end
      reset = 0;
      tick();
      reset = 1;
      m_pc = 32'h0; m_cnt = 32'h0;
    end
`else
    do_instr(0, 32'h40, 32'h0, 0, 1, 5'd5, 1, 0, 0, 0);
    checks++;
    if (pc !== 32'hC || trap !== 1'b0) begin errors++; $display("FAIL illegal_nop: pc=%h trap=%b required c and 0", pc, trap); end
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_jalr();
    test_wrap();
    test_run_stop();
    test_random();
    test_reset_in_mem();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
